// File: rtl/noc_pkg.sv
// Shared NoC constants and types.
//   FLIT_W       : flit width in bits
//   LINK_DEPTH   : default link buffer depth (entries)
//   LINK_CREDITS : default credit count toward the downstream buffer
//   flit_t       : opaque flit payload
package noc_pkg;
  localparam int FLIT_W       = 20;
  localparam int LINK_DEPTH   = 4;
  localparam int LINK_CREDITS = 4;

  typedef logic [FLIT_W-1:0] flit_t;
endpackage

// File: rtl/link_flit_buffer_if.sv
// Link handshake bundle around a credit-based flit buffer.
//   in/vi : flit and valid arriving from the upstream router
//   co    : credit pulse returned to the upstream router
//   o/vo  : flit and valid sent to the downstream router
//   ci    : credit pulse returned by the downstream router
// The slave modport is the buffer's view; master is the surrounding routers.
interface link_flit_buffer_if #(
  parameter int FLIT_W = noc_pkg::FLIT_W
);
  logic [FLIT_W-1:0] in;
  logic              vi;
  logic              co;
  logic [FLIT_W-1:0] o;
  logic              vo;
  logic              ci;

  modport master (output in, vi, ci, input co, o, vo);
  modport slave  (input in, vi, ci, output co, o, vo);
endinterface

// File: rtl/credit_counter.sv
// Saturating up/down credit counter.
//   clk, rst_n : clock, synchronous active-low reset (count returns to MAX)
//   inc        : credit returned by the receiver
//   dec        : credit consumed by a send; only asserted while avail=1
//   avail      : at least one credit is held
//   credit_err : sticky; a credit arrived while the count was already MAX
module credit_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic avail,
  output logic credit_err
);
  localparam int            CW    = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    // A return and a send on the same edge cancel out.
    if (inc && !dec) begin
      if (count_q == MAX_C) err_d = 1'b1;
      else                  count_d = count_q + 1'b1;
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= MAX_C;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign avail      = (count_q != '0);
  assign credit_err = err_q;
endmodule

// File: rtl/link_flit_buffer.sv
// Credit-based link input buffer: circular FIFO of opaque flits, forwarded
// downstream only while downstream credits remain; one credit pulse is
// returned upstream per flit popped.
//   clk, RST   : clock, synchronous active-low reset
//   lnk        : link_flit_buffer_if.slave (in/vi/co upstream, o/vo/ci downstream)
//   occupancy  : current fill level
//   overflow   : sticky; a flit arrived while full with no pop
//   credit_err : sticky; downstream credit arrived with the counter at DOWN_CREDITS
// Optional (LINK_FLIT_BUFFER_STATS_EN):
//   flit_count  : flits sent downstream, wrapping at 16 bits
//   stall_count : cycles with data held but no credit, saturating at 0xFFFF
module link_flit_buffer #(
  parameter int FLIT_W       = noc_pkg::FLIT_W,
  parameter int DEPTH        = noc_pkg::LINK_DEPTH,
  parameter int DOWN_CREDITS = noc_pkg::LINK_CREDITS
) (
  input  logic                   clk,
  input  logic                   RST,
  link_flit_buffer_if.slave      lnk,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow,
  output logic                   credit_err
`ifdef LINK_FLIT_BUFFER_STATS_EN
  ,
  output logic [15:0]            flit_count,
  output logic [15:0]            stall_count
`endif
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam int               OCC_W    = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_LVL = OCC_W'(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [FLIT_W-1:0] o_q, o_d;
  logic              vo_q, vo_d, co_q, co_d, ovf_q, ovf_d;
  logic              credit_avail, full, pop, push;

  assign full = (occ_q == FULL_LVL);
  assign pop  = (occ_q != '0) && credit_avail;
  // A full FIFO still accepts a flit when the head leaves on the same edge.
  assign push = lnk.vi && (!full || pop);

  credit_counter #(.MAX(DOWN_CREDITS)) u_credit (
    .clk        (clk),
    .rst_n      (RST),
    .inc        (lnk.ci),
    .dec        (pop),
    .avail      (credit_avail),
    .credit_err (credit_err)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    o_d      = o_q;
    vo_d     = pop;
    co_d     = pop;
    ovf_d    = ovf_q | (lnk.vi & ~push);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      o_d      = mem[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      o_q      <= '0;
      vo_q     <= 1'b0;
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      o_q      <= o_d;
      vo_q     <= vo_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: storage is not reset; occupancy and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= lnk.in;
  end

  assign lnk.o     = o_q;
  assign lnk.vo    = vo_q;
  assign lnk.co    = co_q;
  assign occupancy = occ_q;
  assign overflow  = ovf_q;

`ifdef LINK_FLIT_BUFFER_STATS_EN
  logic [15:0] flit_cnt_q, flit_cnt_d, stall_cnt_q, stall_cnt_d;

  always_comb begin
    flit_cnt_d  = flit_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (pop) flit_cnt_d = flit_cnt_q + 16'd1;
    if (occ_q != '0 && !credit_avail && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      flit_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      flit_cnt_q  <= flit_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flit_count  = flit_cnt_q;
  assign stall_count = stall_cnt_q;
`endif
endmodule

// File: tb/tb_link_flit_buffer.sv
// Directed self-checking bench for link_flit_buffer (DEPTH=4, DOWN_CREDITS=4).
// Inputs change 2 ns after each rising edge; outputs are sampled at the same
// point, so each check sees the result of the edge just taken.
module tb_link_flit_buffer;
  import noc_pkg::*;

  logic       clk = 1'b0;
  logic       RST;
  logic [2:0] occupancy;
  logic       overflow;
  logic       credit_err;
`ifdef LINK_FLIT_BUFFER_STATS_EN
  logic [15:0] flit_count, stall_count;
`endif

  int checks = 0;
  int errors = 0;

  link_flit_buffer_if lnk ();

  link_flit_buffer dut (
    .clk        (clk),
    .RST        (RST),
    .lnk        (lnk.slave),
    .occupancy  (occupancy),
    .overflow   (overflow),
    .credit_err (credit_err)
`ifdef LINK_FLIT_BUFFER_STATS_EN
    ,
    .flit_count (flit_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST    = 1'b0;
    lnk.in = '0;
    lnk.vi = 1'b0;
    lnk.ci = 1'b0;

    // Reset then idle.
    tick(); tick();
    check("rst_o", 32'(lnk.o), 0);
    check("rst_vo", 32'(lnk.vo), 0);
    check("rst_co", 32'(lnk.co), 0);
    check("rst_occ", 32'(occupancy), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_cerr", 32'(credit_err), 0);
    RST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_vo", 32'(lnk.vo), 0);
      check("idle_co", 32'(lnk.co), 0);
      check("idle_occ", 32'(occupancy), 0);
      check("idle_ovf", 32'(overflow), 0);
    end

    // Single flit: written at edge N, visible after edge N+1.
    lnk.vi = 1'b1; lnk.in = 20'hABCDE;
    tick();
    check("single_occ_n", 32'(occupancy), 1);
    check("single_vo_n", 32'(lnk.vo), 0);
    lnk.vi = 1'b0;
    tick();
    check("single_vo", 32'(lnk.vo), 1);
    check("single_o", 32'(lnk.o), 32'h000ABCDE);
    check("single_co", 32'(lnk.co), 1);
    check("single_occ", 32'(occupancy), 0);
    lnk.ci = 1'b1;                       // return the credit: counter back to 4
    tick();
    check("single_vo_off", 32'(lnk.vo), 0);
    check("single_co_off", 32'(lnk.co), 0);
    lnk.ci = 1'b0;

    // Credit exhaustion: flits 1..6 back to back, no credits returned.
    lnk.vi = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      lnk.in = 20'(i);
      tick();
      if (i >= 2 && i <= 5) begin
        check("exh_vo", 32'(lnk.vo), 1);
        check("exh_o", 32'(lnk.o), 32'(i - 1));
        check("exh_co", 32'(lnk.co), 1);
      end else begin
        check("exh_vo_idle", 32'(lnk.vo), 0);
      end
      check("exh_occ", 32'(occupancy), (i == 6) ? 2 : 1);
    end
    lnk.vi = 1'b0;
    tick();
    check("exh_held_vo", 32'(lnk.vo), 0);
    check("exh_held_occ", 32'(occupancy), 2);
    // First ci restores one credit; second ci coincides with the send of flit 5.
    lnk.ci = 1'b1;
    tick();
    check("ret1_vo", 32'(lnk.vo), 0);
    tick();
    check("ret2_vo", 32'(lnk.vo), 1);
    check("ret2_o", 32'(lnk.o), 5);
    check("ret2_occ", 32'(occupancy), 1);
    lnk.ci = 1'b0;
    tick();                               // counter still 1 -> flit 6 goes
    check("ret3_vo", 32'(lnk.vo), 1);
    check("ret3_o", 32'(lnk.o), 6);
    check("ret3_occ", 32'(occupancy), 0);
    tick();
    check("ret4_vo", 32'(lnk.vo), 0);
    check("ret4_o_hold", 32'(lnk.o), 6);

    // Overflow: no credits, fill to 4, then one more flit is dropped.
    lnk.vi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lnk.in = 20'h100 + 20'(i);
      tick();
      check("fill_occ", 32'(occupancy), 32'(i + 1));
      check("fill_vo", 32'(lnk.vo), 0);
    end
    lnk.in = 20'h12345;
    tick();
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_occ", 32'(occupancy), 4);
    lnk.vi = 1'b0;
    tick();
    check("ovf_sticky", 32'(overflow), 1);

    // Full FIFO with a credit: write accepted alongside the pop.
    lnk.ci = 1'b1;
    tick();
    check("full_credit_vo", 32'(lnk.vo), 0);
    lnk.ci = 1'b0; lnk.vi = 1'b1; lnk.in = 20'h104;
    tick();
    check("full_pop_vo", 32'(lnk.vo), 1);
    check("full_pop_o", 32'(lnk.o), 32'h100);
    check("full_pop_occ", 32'(occupancy), 4);
    check("full_pop_ovf", 32'(overflow), 1);
    // Drain with ci held: send and ci coincide, counter stays at 1.
    lnk.vi = 1'b0; lnk.ci = 1'b1;
    tick();
    check("drain_pre_vo", 32'(lnk.vo), 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("drain_vo", 32'(lnk.vo), 1);
      check("drain_o", 32'(lnk.o), 32'h100 + 32'(k));
      check("drain_occ", 32'(occupancy), 32'(4 - k));
    end
    tick();                               // counter 2
    check("drain_done_vo", 32'(lnk.vo), 0);
    tick();                               // counter 3
    tick();                               // counter 4
    check("cerr_before", 32'(credit_err), 0);
    tick();                               // ci at 4 -> error
    check("cerr_set", 32'(credit_err), 1);
    lnk.ci = 1'b0;
    tick();
    check("cerr_sticky", 32'(credit_err), 1);

    // Mid-operation reset: 4 sent, 3 held, then reset.
    lnk.vi = 1'b1;
    for (int i = 0; i < 7; i++) begin
      lnk.in = 20'h200 + 20'(i);
      tick();
      if (i >= 1 && i <= 4) check("pre_rst_o", 32'(lnk.o), 32'h200 + 32'(i - 1));
    end
    lnk.vi = 1'b0;
    tick();
    check("pre_rst_occ", 32'(occupancy), 3);
    check("pre_rst_vo", 32'(lnk.vo), 0);
    RST = 1'b0;
    tick();
    check("mrst_o", 32'(lnk.o), 0);
    check("mrst_vo", 32'(lnk.vo), 0);
    check("mrst_co", 32'(lnk.co), 0);
    check("mrst_occ", 32'(occupancy), 0);
    check("mrst_ovf", 32'(overflow), 0);
    check("mrst_cerr", 32'(credit_err), 0);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_vo", 32'(lnk.vo), 0);
      check("post_rst_occ", 32'(occupancy), 0);
    end
    lnk.vi = 1'b1; lnk.in = 20'h00777;
    tick();
    lnk.vi = 1'b0;
    tick();
    check("post_rst_flit_vo", 32'(lnk.vo), 1);
    check("post_rst_flit_o", 32'(lnk.o), 32'h777);
    check("post_rst_flit_co", 32'(lnk.co), 1);
`ifdef LINK_FLIT_BUFFER_STATS_EN
    check("stats_flits", 32'(flit_count), 1);
    check("stats_stall", 32'(stall_count), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/link_flit_buffer.md
Name: link_flit_buffer

Overview:
- Credit-based input buffer on the link between a node's router output port (o*/vo*/co*) and the next hop's router input port.
- Stores 20-bit flits from the upstream router in a circular FIFO.
- Forwards flits downstream only when downstream credits are available.
- Returns one credit pulse upstream per flit it frees.
- Used on mesh links, and on the inject path between the processor element and router port 5.

Parameters:
- FLIT_W, 20, flit width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DOWN_CREDITS, 4, initial and maximum credit count toward the downstream buffer.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-low reset.
- in  input  FLIT_W  flit from upstream.
- vi  input  1  flit valid from upstream.
- co  output  1  credit to upstream; one-cycle pulse per flit popped.
- o  output  FLIT_W  flit to downstream.
- vo  output  1  flit valid to downstream; one-cycle pulse per flit.
- ci  input  1  credit from downstream; one-cycle pulse per slot freed.
- occupancy  output  $clog2(DEPTH)+1  current FIFO fill level.
- overflow  output  1  sticky flag: a flit was dropped.
- credit_err  output  1  sticky flag: ci arrived while the credit counter was already at DOWN_CREDITS.

Behaviour:
- Reset: when RST=0 at a clock edge:
  - o=0, vo=0, co=0, occupancy=0, overflow=0, credit_err=0.
  - Read and write pointers = 0; credit counter = DOWN_CREDITS.
  - Reset mid-operation discards all buffered flits and in-flight credits.
- Outputs o, vo, co are registered; no combinational path from any input to any output.
- Write: when vi=1, in is stored at the write pointer, provided the FIFO is not full or a pop occurs the same edge.
  - A write while full with no pop drops the flit, sets overflow, and leaves occupancy unchanged.
- Pop/send:
  - Fires at an edge when occupancy>0 and the credit counter is >0.
  - On that edge: o<=head flit, vo<=1, co<=1, read pointer advances, credit counter decrements.
  - Otherwise vo<=0 and co<=0; o holds its last value.
- Latency: a flit written into an empty FIFO at edge N (credit available) appears on o with vo=1 after edge N+1. There is no same-edge bypass.
- Throughput: one flit per cycle sustained when credits are continuously returned.
- Credit counter:
  - ci=1 increments it; a send decrements it.
  - ci and send on the same edge leave it unchanged.
  - ci at DOWN_CREDITS with no send: counter stays, credit_err set.
- Occupancy: +1 on accepted write, -1 on pop, unchanged when both occur.
- Pointers wrap modulo DEPTH. Full is occupancy==DEPTH; empty is occupancy==0.
- Flit contents are opaque; no field is decoded.

Optional Feature:
- Macro: LINK_FLIT_BUFFER_STATS_EN.
- When defined:
  - Adds output flit_count[15:0]: total flits sent downstream, wrapping at 16 bits, reset to 0.
  - Adds output stall_count[15:0]: cycles where occupancy>0 and credit counter==0, saturating at 0xFFFF, reset to 0.
- When undefined: neither port nor either counter exists; all other behaviour is identical.

Decomposition:
- Shared package noc_pkg holds:
  - FLIT_W = 20.
  - The default link depth constant.
  - The default credit constant.
  - A flit_t typedef (logic [FLIT_W-1:0]).
- One natural sub-module: credit_counter (the saturating up/down counter plus credit_err). It is reused on the router's output side.
- FIFO storage and pointers stay inline.

Test Plan:
- Reset then idle: after RST=0 for 2 cycles, then RST=1 with vi=0 -> vo=0, co=0, occupancy=0, overflow=0 for 10 cycles.
- Single flit, credits available: vi=1, in=20'hABCDE at edge N -> vo=1, o=20'hABCDE, co=1 after edge N+1; occupancy 1 then 0.
- Credit exhaustion, DEPTH=4, DOWN_CREDITS=4, ci held 0:
  - Write 6 flits 1..6 on consecutive cycles -> flits 1..4 sent, then vo=0.
  - Flits 5 and 6 are held: occupancy=2.
  - Pulse ci twice -> flits 5 and 6 emitted in order, one per cycle.
- Overflow: ci=0 after credits are exhausted, FIFO filled to 4, vi=1 with in=20'h12345 -> flit dropped, overflow=1, occupancy stays 4; flag persists until reset.
- Simultaneous events:
  - Full FIFO, credit>0, vi=1 -> write accepted alongside pop; occupancy stays 4; order preserved.
  - ci and send on the same edge -> credit counter unchanged.
- Credit error and mid-operation reset:
  - ci pulse at counter=4 with no send -> credit_err=1.
  - Assert RST=0 with 3 flits buffered -> all outputs and flags cleared next edge; no stale flit emitted afterwards.
